lcd_display_sequencer: RTL

- Controls the LCD timing/pattern generator on the Tang Nano 20k panel path. Drives the panel power-up and power-down sequence: panel power, then the timing-generator enable, then the backlight.
- Holds the pattern configuration registers that the generator reads: background and rectangle colours, coordinates and pattern select.
- Config writes land in shadow registers through a valid/ready port. They are committed to the active registers only at a frame boundary, so the picture never tears mid-frame.

---
 rtl/lcd_display_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/lcd_display_sequencer.sv
// LCD panel power/timing/backlight sequencer with frame-synchronous config commit.
// Optional LCD_SEQ_AUTO_CYCLE_EN: steps pattern select (reg0[3:0]) every CYCLE_FRAMES frames in ON.
module lcd_display_sequencer #(
   parameter logic [15:0] PWR_DLY       = 16'd1000,
   parameter logic [3:0]  BL_FRAMES     = 4'd3,
   parameter bit          VS_ACTIVE_LOW = 1'b1,
   parameter int          NUM_REGS      = 8,
   parameter logic [15:0] CYCLE_FRAMES  = 16'd120,
   parameter logic [3:0]  NUM_PATTERNS  = 4'd6
) (
   input  logic                    PixelClk,
   input  logic                    nRST,
   input  logic                    pwr_req,
   input  logic                    LCD_VSYNC,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [2:0]              cfg_addr,
   input  logic [15:0]             cfg_data,
   input  logic                    cfg_commit,
   output logic [NUM_REGS*16-1:0]  ACT_REGS,
   output logic                    commit_done,
   output logic                    LCD_PWR,
   output logic                    TIMING_EN,
   output logic                    LCD_BL,
   output logic [2:0]              STATE
);

   typedef enum logic [2:0] {
      S_OFF     = 3'd0,
      S_PWR_ON  = 3'd1,
      S_TIMING  = 3'd2,
      S_ON      = 3'd3,
      S_BL_OFF  = 3'd4,
      S_PWR_OFF = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        vs_q;
   logic        lcd_pwr_q, lcd_pwr_d;
   logic        timing_en_q, timing_en_d;
   logic        lcd_bl_q, lcd_bl_d;
   logic        pend_q, pend_d;
   logic        done_q, done_d;
   logic [15:0] shadow_q [NUM_REGS];
   logic [15:0] shadow_d [NUM_REGS];
   logic [15:0] act_q [NUM_REGS];
   logic [15:0] act_d [NUM_REGS];
   logic        tick, accept, commit;

   // Frame tick: edge between the history flop and the live vsync, only while timing runs
   assign tick   = timing_en_q & (VS_ACTIVE_LOW ? (vs_q & ~LCD_VSYNC) : (~vs_q & LCD_VSYNC));
   assign accept = cfg_valid & ~pend_q;
   assign commit = pend_q & (timing_en_q ? tick : 1'b1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_OFF:     if (pwr_req) state_d = S_PWR_ON;
         S_PWR_ON: begin
            if (!pwr_req)                      state_d = S_PWR_OFF;
            else if (cnt_q == PWR_DLY - 16'd1) state_d = S_TIMING;
            else                               cnt_d   = cnt_q + 16'd1;
         end
         S_TIMING: begin
            if (!pwr_req) state_d = S_PWR_OFF;
            else if (tick) begin
               if (cnt_q == {12'd0, BL_FRAMES} - 16'd1) state_d = S_ON;
               else                                     cnt_d   = cnt_q + 16'd1;
            end
         end
         S_ON:      if (!pwr_req) state_d = S_BL_OFF;
         S_BL_OFF: begin
            if (tick) begin
               if (cnt_q == {12'd0, BL_FRAMES} - 16'd1) state_d = S_PWR_OFF;
               else                                     cnt_d   = cnt_q + 16'd1;
            end
         end
         S_PWR_OFF: begin
            if (cnt_q == PWR_DLY - 16'd1) state_d = S_OFF;
            else                          cnt_d   = cnt_q + 16'd1;
         end
         default:   state_d = S_OFF;
      endcase
      if (state_d != state_q) cnt_d = 16'd0;
      lcd_pwr_d   = (state_d != S_OFF);
      timing_en_d = (state_d == S_TIMING) || (state_d == S_ON) || (state_d == S_BL_OFF);
      lcd_bl_d    = (state_d == S_ON);
   end

`ifdef LCD_SEQ_AUTO_CYCLE_EN
   logic [15:0] fcnt_q, fcnt_d;
   logic        step;

   always_comb begin
      fcnt_d = fcnt_q;
      step   = 1'b0;
      if (state_q != S_ON) fcnt_d = 16'd0;
      else if (tick) begin
         if (commit)                                  fcnt_d = 16'd0;
         else if (fcnt_q == CYCLE_FRAMES - 16'd1) begin
            fcnt_d = 16'd0;
            step   = 1'b1;
         end
         else                                         fcnt_d = fcnt_q + 16'd1;
      end
   end

   always_ff @(posedge PixelClk or negedge nRST) begin
      if (!nRST) fcnt_q <= 16'd0;
      else       fcnt_q <= fcnt_d;
   end
`else
   logic step;
   logic unused_auto_params;
   assign step               = 1'b0;
   assign unused_auto_params = ^{CYCLE_FRAMES, NUM_PATTERNS};
`endif

   always_comb begin
      shadow_d = shadow_q;
      act_d    = act_q;
      pend_d   = pend_q;
      if (accept && (32'(cfg_addr) < NUM_REGS)) shadow_d[cfg_addr] = cfg_data;
      if (accept && cfg_commit) pend_d = 1'b1;
      if (commit) begin
         act_d  = shadow_q;
         pend_d = 1'b0;
      end
      else if (step) begin
         act_d[0][3:0] = (act_q[0][3:0] >= NUM_PATTERNS - 4'd1) ? 4'd0 : act_q[0][3:0] + 4'd1;
      end
      done_d = commit;
   end

   always_ff @(posedge PixelClk or negedge nRST) begin
      if (!nRST) begin
         state_q     <= S_OFF;
         cnt_q       <= 16'd0;
         vs_q        <= VS_ACTIVE_LOW;
         lcd_pwr_q   <= 1'b0;
         timing_en_q <= 1'b0;
         lcd_bl_q    <= 1'b0;
         pend_q      <= 1'b0;
         done_q      <= 1'b0;
         for (int k = 0; k < NUM_REGS; k++) begin
            shadow_q[k] <= 16'd0;
            act_q[k]    <= 16'd0;
         end
      end
      else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         vs_q        <= LCD_VSYNC;
         lcd_pwr_q   <= lcd_pwr_d;
         timing_en_q <= timing_en_d;
         lcd_bl_q    <= lcd_bl_d;
         pend_q      <= pend_d;
         done_q      <= done_d;
         shadow_q    <= shadow_d;
         act_q       <= act_d;
      end
   end

   always_comb begin
      for (int k = 0; k < NUM_REGS; k++) ACT_REGS[16*k +: 16] = act_q[k];
   end

   assign cfg_ready   = ~pend_q;
   assign commit_done = done_q;
   assign LCD_PWR     = lcd_pwr_q;
   assign TIMING_EN   = timing_en_q;
   assign LCD_BL      = lcd_bl_q;
   assign STATE       = state_q;

endmodule
